dec_scan_reg: RTL and testbench

DEC_SCAN_REG -- requirements
Module: dec_scan_reg

---
 rtl/dec_scan_reg_if.sv | 27 ++
 rtl/dec_scan_reg.sv | 125 ++++++++++++
 tb/tb_dec_scan_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dec_scan_reg_if.sv
// Bus bundle for dec_scan_reg: control/code inputs and registered decode outputs.
// The master side drives the controls; the slave side is the decoder.
interface dec_scan_reg_if #(
  parameter int SEL_W = 4,
  parameter int DIV_W = 8
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic [SEL_W-1:0] in_sel;
  logic [DIV_W-1:0] div;
  logic [OUT_W-1:0] y;
  logic             y_valid;
  logic             scan_wrap;

  modport master (
    output en, mode, in_valid, in_sel, div,
    input  y, y_valid, scan_wrap
  );

  modport slave (
    input  en, mode, in_valid, in_sel, div,
    output y, y_valid, scan_wrap
  );
endinterface

// File: rtl/dec_scan_reg.sv
// dec_scan_reg: registered one-hot decoder with an optional scanning mode.
// Direct mode latches 1<<in_sel on in_valid and holds it between strobes.
// Scan mode (build macro DEC_SCAN_EN) walks the one-hot bit across all
// outputs, dwelling div+1 cycles per position and pulsing scan_wrap when the
// walk returns to bit 0. Without DEC_SCAN_EN, mode and div are ignored and
// scan_wrap stays low.
module dec_scan_reg #(
  parameter int SEL_W = 4,
  parameter int DIV_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  dec_scan_reg_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;

  if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
    $error("dec_scan_reg: SEL_W must be in 1..6");
  end

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             scan_wrap_q, scan_wrap_d;
  logic             scan_req;

`ifdef DEC_SCAN_EN
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] pre_q, pre_d;

  assign scan_req = bus.mode;
`else
  logic unused_cfg;

  assign unused_cfg = ^{bus.mode, bus.div};
  assign scan_req   = 1'b0;
`endif

  // Next-state and output decode; every path starts from "hold".
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    scan_wrap_d = 1'b0;
`ifdef DEC_SCAN_EN
    idx_d       = idx_q;
    pre_d       = pre_q;
`endif
    if (!bus.en) begin
      state_d   = IDLE;
      y_d       = '0;
      y_valid_d = 1'b0;
`ifdef DEC_SCAN_EN
      idx_d     = '0;
      pre_d     = '0;
`endif
    end else if (scan_req) begin
      state_d = SCAN;
`ifdef DEC_SCAN_EN
      if (state_q != SCAN) begin
        // Fresh scan always starts at bit 0 with an empty dwell.
        idx_d     = '0;
        pre_d     = '0;
        y_d       = OUT_W'(1);
        y_valid_d = 1'b1;
      end else if (pre_q == bus.div) begin
        // Dwell complete: step to the next bit, wrapping naturally at SEL_W bits.
        pre_d       = '0;
        idx_d       = idx_q + SEL_W'(1);
        y_d         = OUT_W'(1) << idx_d;
        scan_wrap_d = (idx_q == SEL_W'(OUT_W - 1));
      end else begin
        pre_d = pre_q + DIV_W'(1);
      end
`endif
    end else begin
      state_d = DIRECT;
`ifdef DEC_SCAN_EN
      // Leaving scan keeps the visible bit but forgets scan progress.
      if (state_q == SCAN) begin
        idx_d = '0;
        pre_d = '0;
      end
`endif
      if (bus.in_valid) begin
        y_d       = OUT_W'(1) << bus.in_sel;
        y_valid_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

`ifdef DEC_SCAN_EN
  // Scan index and dwell prescaler, cleared asynchronously with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      pre_q <= '0;
    end else begin
      idx_q <= idx_d;
      pre_q <= pre_d;
    end
  end
`endif

  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.scan_wrap = scan_wrap_q;
endmodule

// File: tb/tb_dec_scan_reg.sv
// Directed bench for dec_scan_reg (SEL_W=4, DIV_W=8). Scan-mode steps are
// built when DEC_SCAN_EN is defined; otherwise the direct-only build is checked.
module tb_dec_scan_reg;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dec_scan_reg_if #(.SEL_W(4), .DIV_W(8)) bus ();

  dec_scan_reg #(.SEL_W(4), .DIV_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  sel_tab [4] = '{4'd0, 4'd15, 4'd9, 4'd3};
  logic [15:0] exp_tab [4] = '{16'h0001, 16'h8000, 16'h0200, 16'h0008};

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    bus.div      = '0;
    step();
    step();
    chk("rst_y", bus.y, 16'h0000);
    chk("rst_y_valid", bus.y_valid, 1'b0);
    chk("rst_wrap", bus.scan_wrap, 1'b0);

    // Direct decode and sticky hold.
    rst_n        = 1'b1;
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd5;
    step();
    chk("dir_y5", bus.y, 16'h0020);
    chk("dir_v5", bus.y_valid, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_sel   = 4'd9;
    step();
    chk("hold_y", bus.y, 16'h0020);
    step();
    chk("hold_y2", bus.y, 16'h0020);
    chk("hold_v", bus.y_valid, 1'b1);

    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel = sel_tab[i];
      step();
      chk("dir_tab", bus.y, exp_tab[i]);
    end

    // Disable clears outputs; re-enable without a strobe keeps them clear.
    bus.en = 1'b0;
    step();
    chk("dis_y", bus.y, 16'h0000);
    chk("dis_v", bus.y_valid, 1'b0);
    bus.en       = 1'b1;
    bus.in_valid = 1'b0;
    step();
    chk("reen_y", bus.y, 16'h0000);
    chk("reen_v", bus.y_valid, 1'b0);

    // Asynchronous reset between clock edges.
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd3;
    step();
    chk("pre_rst_y", bus.y, 16'h0008);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", bus.y, 16'h0000);
    chk("async_rst_v", bus.y_valid, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_y", bus.y, 16'h0000);
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd12;
    step();
    chk("post_rst_dec", bus.y, 16'h1000);

`ifdef DEC_SCAN_EN
    // Scan with div=2; in_valid/in_sel must be ignored.
    bus.mode     = 1'b1;
    bus.div      = 8'd2;
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd15;
    step();
    chk("scan_entry_y", bus.y, 16'h0001);
    chk("scan_entry_v", bus.y_valid, 1'b1);
    chk("scan_entry_wrap", bus.scan_wrap, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      step();
      chk("scan_d2_y", bus.y, 16'h0001 << ((k / 3) % 16));
      chk("scan_d2_wrap", bus.scan_wrap, (k == 48) ? 1'b1 : 1'b0);
    end

    // div=0 advances every cycle from here (index 0, dwell empty).
    bus.div = 8'd0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("scan_d0_y", bus.y, 16'h0001 << (k % 16));
      chk("scan_d0_wrap", bus.scan_wrap, (k % 16 == 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 6; k++) step();
    chk("scan_at_40", bus.y, 16'h0040);

    // Drop enable for one cycle mid-scan.
    bus.en = 1'b0;
    step();
    chk("scan_dis_y", bus.y, 16'h0000);
    chk("scan_dis_v", bus.y_valid, 1'b0);
    bus.en = 1'b1;
    step();
    chk("scan_reen_y", bus.y, 16'h0001);
    chk("scan_reen_v", bus.y_valid, 1'b1);

    // Reset mid-dwell at 0x0100.
    bus.div = 8'd2;
    bus.en  = 1'b0;
    step();
    bus.en = 1'b1;
    step();
    for (int k = 0; k < 24; k++) step();
    chk("scan_at_100", bus.y, 16'h0100);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("scan_rst_y", bus.y, 16'h0000);
    chk("scan_rst_wrap", bus.scan_wrap, 1'b0);
    rst_n = 1'b1;
    step();
    chk("scan_restart", bus.y, 16'h0001);

    // Scan -> direct: hold until the first strobe.
    for (int k = 0; k < 4; k++) step();
    chk("scan_at_2", bus.y, 16'h0002);
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("s2d_hold_y", bus.y, 16'h0002);
    chk("s2d_hold_v", bus.y_valid, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd7;
    step();
    chk("s2d_dec", bus.y, 16'h0080);
`else
    // Direct-only build: mode and div have no effect, no wrap pulses.
    bus.mode     = 1'b1;
    bus.div      = 8'd0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 4'd15;
    step();
    chk("nscan_y", bus.y, 16'h8000);
    chk("nscan_v", bus.y_valid, 1'b1);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("nscan_hold", bus.y, 16'h8000);
      chk("nscan_wrap", bus.scan_wrap, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
